// File: rtl/l2_miss_controller.sv
// l2_miss_controller: single-outstanding request controller in front of the L2 data-cache core.
// Serves L1 hits in two cycles. Misses pick a victim, write it back if dirty, refill the line
// and replay the request. Define L2_PERF_CNT_EN to add the perf_hit/perf_miss/perf_wb counters.
module l2_miss_controller #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned CACHE_SIZE  = 1048576,
  parameter int unsigned LINE_SIZE   = 64,
  parameter int unsigned WAYS        = 16,
  localparam int unsigned WW         = $clog2(WAYS),
  localparam int unsigned LW         = LINE_SIZE * 8
) (
  input  logic                   clk,
  input  logic                   rst,
  // L1 request / response
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [DATA_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [DATA_LENGTH-1:0] resp_rdata,
  // Core lookup
  output logic                   query_valid,
  output logic [31:0]            query_addr,
  input  logic                   query_hit,
  input  logic [WW-1:0]          query_hit_way,
  input  logic [DATA_LENGTH-1:0] query_data_out,
  input  logic [WAYS-1:0]        valid_per_way,
  // Core word write
  output logic                   do_store,
  output logic [WW-1:0]          store_way,
  output logic [31:0]            store_addr,
  output logic [DATA_LENGTH-1:0] store_data_in,
  // Victim select / readback
  output logic [WW-1:0]          victim_way,
  output logic [31:0]            victim_addr,
  input  logic [31:0]            victim_tag_out,
  input  logic                   victim_dirty_out,
  input  logic [LW-1:0]          victim_line_data_out,
  // Refill
  output logic                   do_update_line,
  output logic                   do_update_tag_and_valid,
  output logic [31:0]            update_addr,
  output logic [WW-1:0]          update_way,
  output logic [LW-1:0]          update_line_data,
  output logic                   update_dirty_bit,
  // Memory
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [31:0]            mem_req_addr,
  output logic [LW-1:0]          mem_req_wdata,
  input  logic                   mem_resp_valid,
  input  logic [LW-1:0]          mem_resp_data
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]            perf_hit,
  output logic [31:0]            perf_miss,
  output logic [31:0]            perf_wb
`endif
);

  localparam int unsigned SETS = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int unsigned OFF  = $clog2(LINE_SIZE);
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAG  = 32 - IDX - OFF;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StVictim,
    StWbReq,
    StRfReq,
    StRfWait,
    StUpdate
  } state_e;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [DATA_LENGTH-1:0] wdata_q, wdata_d;
  logic                   replay_q, replay_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_LENGTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [WW-1:0]          vway_q, vway_d;
  logic                   vall_q, vall_d;
  logic [TAG-1:0]         wb_tag_q, wb_tag_d;
  logic [LW-1:0]          wb_line_q, wb_line_d;
  logic [LW-1:0]          rf_line_q, rf_line_d;
  logic [WW-1:0]          rr_q, rr_d;

  logic [WW-1:0]  free_way;
  logic           all_valid;
  logic [WW-1:0]  pick_way;
  logic [31:0]    line_addr;
  logic [IDX-1:0] set_idx;
  logic           unused_tag_hi;

  assign line_addr     = {addr_q[31:OFF], {OFF{1'b0}}};
  assign set_idx       = addr_q[OFF+IDX-1:OFF];
  assign all_valid     = &valid_per_way;
  assign pick_way      = all_valid ? rr_q : free_way;
  // Tag bits above TAG are not part of the line address.
  assign unused_tag_hi = ^victim_tag_out[31:TAG];

  // Lowest-index invalid way of the addressed set.
  always_comb begin
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_per_way[i]) free_way = WW'(i);
    end
  end

  // Next-state, datapath capture and all strobe/payload outputs.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    replay_d       = replay_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    vway_d         = vway_q;
    vall_d         = vall_q;
    wb_tag_d       = wb_tag_q;
    wb_line_d      = wb_line_q;
    rf_line_d      = rf_line_q;
    rr_d           = rr_q;

    query_valid             = 1'b0;
    query_addr              = '0;
    do_store                = 1'b0;
    store_way               = '0;
    store_addr              = '0;
    store_data_in           = '0;
    victim_way              = '0;
    victim_addr             = '0;
    do_update_line          = 1'b0;
    do_update_tag_and_valid = 1'b0;
    update_addr             = '0;
    update_way              = '0;
    update_line_data        = '0;
    update_dirty_bit        = 1'b0;
    mem_req_valid           = 1'b0;
    mem_req_we              = 1'b0;
    mem_req_addr            = '0;
    mem_req_wdata           = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          replay_d = 1'b0;
          state_d  = StLookup;
        end
      end
      StLookup: begin
        query_valid = 1'b1;
        query_addr  = addr_q;
        if (query_hit) begin
          if (we_q) begin
            do_store      = 1'b1;
            store_way     = query_hit_way;
            store_addr    = addr_q;
            store_data_in = wdata_q;
          end
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : query_data_out;
          state_d      = StIdle;
        end else begin
          state_d = StVictim;
        end
      end
      StVictim: begin
        victim_way  = pick_way;
        victim_addr = line_addr;
        vway_d      = pick_way;
        vall_d      = all_valid;
        wb_tag_d    = victim_tag_out[TAG-1:0];
        wb_line_d   = victim_line_data_out;
        state_d     = victim_dirty_out ? StWbReq : StRfReq;
      end
      StWbReq: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {wb_tag_q, set_idx, {OFF{1'b0}}};
        mem_req_wdata = wb_line_q;
        if (mem_req_ready) state_d = StRfReq;
      end
      StRfReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = line_addr;
        if (mem_req_ready) state_d = StRfWait;
      end
      StRfWait: begin
        if (mem_resp_valid) begin
          rf_line_d = mem_resp_data;
          state_d   = StUpdate;
        end
      end
      StUpdate: begin
        do_update_line          = 1'b1;
        do_update_tag_and_valid = 1'b1;
        update_addr             = line_addr;
        update_way              = vway_q;
        update_line_data        = rf_line_q;
        // Round-robin only moves when it actually chose the victim.
        if (vall_q) rr_d = (rr_q == WW'(WAYS - 1)) ? '0 : rr_q + 1'b1;
        replay_d = 1'b1;
        state_d  = StLookup;
      end
      default: state_d = StIdle;
    endcase
  end

  // Held low while rst is high so every output reads 0 during reset.
  assign req_ready  = (state_q == StIdle) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      replay_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      vway_q       <= '0;
      vall_q       <= 1'b0;
      wb_tag_q     <= '0;
      wb_line_q    <= '0;
      rf_line_q    <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      replay_q     <= replay_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      vway_q       <= vway_d;
      vall_q       <= vall_d;
      wb_tag_q     <= wb_tag_d;
      wb_line_q    <= wb_line_d;
      rf_line_q    <= rf_line_d;
      rr_q         <= rr_d;
    end
  end

`ifdef L2_PERF_CNT_EN
  logic        ev_hit, ev_miss, ev_wb;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  assign ev_hit  = (state_q == StLookup) && query_hit && !replay_q;
  assign ev_miss = (state_q == StLookup) && !query_hit;
  assign ev_wb   = (state_q == StWbReq) && mem_req_ready;

  // Saturating event counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (ev_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (ev_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    if (ev_wb && (wb_cnt_q != 32'hFFFF_FFFF)) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign perf_hit  = hit_cnt_q;
  assign perf_miss = miss_cnt_q;
  assign perf_wb   = wb_cnt_q;
`endif

endmodule
